// File: rtl/aes_pkg.sv
// Shared AES definitions: block geometry, word/block types, the Rcon table
// and the key-schedule state encoding.
package aes_pkg;

  localparam int unsigned AES_NB    = 4;
  localparam int unsigned AES128_NR = 10;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ks_state_e;

  // Rcon round bytes for indices 1..10, index 1 in the least significant byte.
  localparam logic [79:0] RCON_TAB = 80'h36_1b_80_40_20_10_08_04_02_01;

  // Rcon word for round index idx (1..10); round byte in [31:24], zero
  // outside the legal range.
  function automatic word_t aes_rcon(input logic [3:0] idx);
    word_t       w;
    int unsigned i;
    w = '0;
    i = int'(idx);
    if (i >= 1 && i <= AES128_NR) begin
      w[31:24] = RCON_TAB[8*(i-1) +: 8];
    end
    return w;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box.
// Ports: in_i  - input byte
//        out_o - substituted byte
module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  // Entry 0x00 is the most significant byte, so entry i sits at offset 255-i.
  localparam logic [2047:0] SBOX_TAB = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // 255-i equals ~i for an 8-bit index.
  always_comb begin
    out_o = SBOX_TAB[{~in_i, 3'b000} +: 8];
  end

endmodule

// File: rtl/key_expand_iter.sv
// Iterative AES-128 key schedule: emits round keys 0..NUM_ROUNDS, one per
// accepted valid/ready transfer, from a single registered round key.
// Ports: clk, rst      - clock, synchronous active-high reset
//        start, key_in - load cipher key (honoured only in IDLE)
//        busy          - schedule in progress
//        rk_valid/rk_ready/rk_round/rk_out - round-key stream
//        done          - one-cycle pulse after the last key is accepted
module key_expand_iter
  import aes_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = AES128_NR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [3:0]   rk_round,
  output logic [127:0] rk_out,
  output logic         done
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  ks_state_e state_q, state_d;
  block_t    rk_q, rk_d;
  logic [3:0] round_q, round_d;
  logic      done_q, done_d;

  word_t  w0, w1, w2, w3, rot_w3, sub_w, t_w;
  word_t  n0, n1, n2, n3;
  logic [3:0] next_round;

  assign {w0, w1, w2, w3} = rk_q;
  assign next_round = round_q + 4'd1;
  // RotWord: [b0,b1,b2,b3] -> [b1,b2,b3,b0] with b0 in the top byte.
  assign rot_w3 = {w3[23:0], w3[31:24]};

  for (genvar i = 0; i < AES_NB; i++) begin : g_subword
    aes_sbox u_sbox (
      .in_i  (rot_w3[8*i +: 8]),
      .out_o (sub_w[8*i +: 8])
    );
  end

  assign t_w = sub_w ^ aes_rcon(next_round);
  assign n0  = w0 ^ t_w;
  assign n1  = w1 ^ n0;
  assign n2  = w2 ^ n1;
  assign n3  = w3 ^ n2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rk_q    <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rk_q    <= rk_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rk_d    = rk_q;
    round_d = round_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          rk_d    = key_in;
          round_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (rk_ready) begin
          if (round_q == LAST_ROUND) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            rk_d    = {n0, n1, n2, n3};
            round_d = next_round;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q == RUN);
  assign rk_valid = (state_q == RUN);
  assign rk_round = round_q;
  assign rk_out   = rk_q;
  assign done     = done_q;

endmodule

// File: tb/tb_key_expand_iter.sv
module tb_key_expand_iter;

  logic         clk = 1'b0;
  logic         rst, start, rk_ready;
  logic [127:0] key_in;
  logic         busy, rk_valid, done;
  logic [3:0]   rk_round;
  logic [127:0] rk_out;

  int checks   = 0;
  int failures = 0;

  logic [127:0] gold [0:10];
  localparam logic [127:0] K1    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2_R1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] K2_R10= 128'h13111d7fe3944a17f307a78b4d2b30c5;

  key_expand_iter #(.NUM_ROUNDS(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key_in   (key_in),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_round (rk_round),
    .rk_out   (rk_out),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; rk_ready = 1'b0; key_in = '0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if ({busy, rk_valid, done, rk_round} !== 7'd0) begin
      failures++;
      $display("FAIL reset_ctrl got busy=%b valid=%b done=%b round=%0d want all 0",
               busy, rk_valid, done, rk_round);
    end
    checks++;
    if (rk_out !== '0) begin
      failures++;
      $display("FAIL reset_rk_out got %h want 0", rk_out);
    end
    tick();
    checks++;
    if (rk_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_hold got valid=%b busy=%b want 0 0", rk_valid, busy);
    end
  endtask

  task automatic test_golden();
    int vcnt = 0;
    key_in = K1; start = 1'b1; rk_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 0; r <= 10; r++) begin
      if (rk_valid === 1'b1) vcnt++;
      checks++;
      if (rk_round !== 4'(r) || rk_out !== gold[r] || rk_valid !== 1'b1 || busy !== 1'b1) begin
        failures++;
        $display("FAIL golden_r%0d got round=%0d key=%h valid=%b busy=%b want round=%0d key=%h valid=1 busy=1",
                 r, rk_round, rk_out, rk_valid, busy, r, gold[r]);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || rk_valid !== 1'b0 || busy !== 1'b0 ||
        rk_out !== gold[10] || rk_round !== 4'd10) begin
      failures++;
      $display("FAIL golden_done got done=%b valid=%b busy=%b round=%0d key=%h want 1 0 0 10 %h",
               done, rk_valid, busy, rk_round, rk_out, gold[10]);
    end
    if (rk_valid === 1'b1) vcnt++;
    tick();
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse_width got done=%b want 0", done);
    end
    checks++;
    if (vcnt != 11) begin
      failures++;
      $display("FAIL valid_count got %0d want 11", vcnt);
    end
  endtask

  task automatic test_stall();
    key_in = K1; start = 1'b1; rk_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 0; r <= 10; r++) begin
      checks++;
      if (rk_round !== 4'(r) || rk_out !== gold[r] || rk_valid !== 1'b1) begin
        failures++;
        $display("FAIL stall_r%0d got round=%0d key=%h valid=%b want round=%0d key=%h",
                 r, rk_round, rk_out, rk_valid, r, gold[r]);
      end
      if (r == 4) begin
        rk_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          tick();
          checks++;
          if (rk_round !== 4'd4 || rk_out !== gold[4] || rk_valid !== 1'b1) begin
            failures++;
            $display("FAIL stall_hold%0d got round=%0d key=%h valid=%b want 4 %h 1",
                     s, rk_round, rk_out, rk_valid, gold[4]);
          end
        end
        rk_ready = 1'b1;
      end
      tick();
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL stall_done got %b want 1", done);
    end
    tick();
  endtask

  task automatic test_start_ignored();
    key_in = K1; start = 1'b1; rk_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 0; r <= 10; r++) begin
      checks++;
      if (rk_round !== 4'(r) || rk_out !== gold[r]) begin
        failures++;
        $display("FAIL ignore_r%0d got round=%0d key=%h want round=%0d key=%h",
                 r, rk_round, rk_out, r, gold[r]);
      end
      if (r == 6) begin
        key_in = K2; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || rk_out !== gold[10]) begin
      failures++;
      $display("FAIL ignore_done got done=%b key=%h want 1 %h", done, rk_out, gold[10]);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int guard;
    key_in = K1; start = 1'b1; rk_ready = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (rk_round !== 4'd3 || rk_out !== gold[3]) begin
      failures++;
      $display("FAIL mid_r3 got round=%0d key=%h want 3 %h", rk_round, rk_out, gold[3]);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (rk_valid !== 1'b0 || busy !== 1'b0 || rk_out !== '0 ||
        rk_round !== 4'd0 || done !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got valid=%b busy=%b round=%0d done=%b key=%h want 0 0 0 0 0",
               rk_valid, busy, rk_round, done, rk_out);
    end
    key_in = K2; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (rk_out !== K2 || rk_round !== 4'd0 || rk_valid !== 1'b1) begin
      failures++;
      $display("FAIL k2_r0 got %h round=%0d valid=%b want %h 0 1", rk_out, rk_round, rk_valid, K2);
    end
    tick();
    checks++;
    if (rk_out !== K2_R1 || rk_round !== 4'd1) begin
      failures++;
      $display("FAIL k2_r1 got %h round=%0d want %h 1", rk_out, rk_round, K2_R1);
    end
    guard = 0;
    while (rk_round !== 4'd10 && guard < 20) begin
      tick();
      guard++;
    end
    checks++;
    if (rk_out !== K2_R10 || rk_round !== 4'd10 || rk_valid !== 1'b1) begin
      failures++;
      $display("FAIL k2_r10 got %h round=%0d valid=%b want %h 10 1", rk_out, rk_round, rk_valid, K2_R10);
    end
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    key_in = K1; start = 1'b1; rk_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 0; r <= 10; r++) tick();
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL b2b_done got %b want 1", done);
    end
    key_in = K2; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (rk_out !== K2 || rk_round !== 4'd0 || rk_valid !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_r0 got %h round=%0d valid=%b busy=%b want %h 0 1 1",
               rk_out, rk_round, rk_valid, busy, K2);
    end
    for (int r = 1; r <= 10; r++) tick();
    checks++;
    if (rk_out !== K2_R10 || rk_round !== 4'd10) begin
      failures++;
      $display("FAIL b2b_r10 got %h round=%0d want %h 10", rk_out, rk_round, K2_R10);
    end
    tick();
    tick();
  endtask

  initial begin
    gold[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    gold[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    gold[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    gold[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    gold[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    gold[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    gold[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    gold[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    gold[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    gold[9]  = 128'hac7766f319fadc2128d12941575c006e;
    gold[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    test_reset();
    test_golden();
    test_stall();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_expand_iter.md
Name: key_expand_iter

Overview:
Iterative AES-128 key-schedule engine that generates round keys 0..10 one per accepted transfer. It sits directly downstream of the round-constant table. It drives the round index into the Rcon lookup and consumes the 32-bit Rcon word (round byte in bits [31:24]). The generated round keys are streamed to the cipher datapath over a valid/ready handshake.

Parameters:
NUM_ROUNDS, 10, index of the last round key emitted. Legal range is 1..10, and 10 is mandatory for AES-128. Smaller values exist only to shorten the schedule in tests.

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  load key_in and begin schedule; honoured only in IDLE
key_in  input  128  cipher key; w0 = [127:96], w3 = [31:0]
busy  output  1  high while not IDLE
rk_valid  output  1  rk_out/rk_round hold a valid round key
rk_ready  input  1  consumer accepts the current round key
rk_round  output  4  index of the round key on rk_out (0..NUM_ROUNDS)
rk_out  output  128  current round key, same word order as key_in
done  output  1  one-cycle pulse on the cycle after round NUM_ROUNDS is accepted

Behaviour:
- Reset values: state=IDLE, busy=0, rk_valid=0, rk_round=0, rk_out=0, done=0. rst overrides all other inputs, including mid-schedule; no partial output survives reset.
- States: IDLE and RUN.
- IDLE, start=1: on the next cycle, rk_out=key_in, rk_round=0, rk_valid=1, busy=1, state=RUN. Latency from start to round key 0 is 1 cycle.
- IDLE, start=0: outputs hold, rk_valid=0.
- RUN, rk_ready=0: rk_out, rk_round and rk_valid=1 hold stable. This is a stall; there is no limit on how long the consumer may stall.
- RUN, rk_ready=1 and rk_round<NUM_ROUNDS: the next cycle presents key rk_round+1 with rk_valid kept high. With rk_ready held high, throughput is 1 key/cycle.
- RUN, rk_ready=1 and rk_round==NUM_ROUNDS: the next cycle has rk_valid=0, busy=0, done=1 for one cycle, state=IDLE. rk_out and rk_round keep their last values.
- start while busy is ignored; a new schedule needs start in IDLE. This includes the cycle where done is high, since state is already IDLE then.
- Next-key arithmetic, all combinational from registered rk_out:
  - t = SubWord(RotWord(w3)) XOR Rcon(rk_round+1)
  - RotWord: bytes [b0,b1,b2,b3] become [b1,b2,b3,b0]
  - SubWord: four AES forward S-box lookups
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'
- Rcon index is rk_round+1, range 1..10. The values are 01,02,04,08,10,20,40,80,1b,36 in bits [31:24], with zeros below.
- rk_round never exceeds NUM_ROUNDS and never wraps.
- A single registered 128-bit key plus a 4-bit counter is sufficient. Earlier round keys are not stored; the consumer buffers them if decryption needs reverse order.

Decomposition:
- Package aes_pkg holds:
  - AES_NB=4 and AES128_NR=10
  - a typedef for the 32-bit word and the 128-bit block
  - the localparam Rcon table
  - the state enum {IDLE, RUN}
- Sub-module aes_sbox: an 8-bit combinational forward S-box, instantiated four times for SubWord. It is shared later with the SubBytes stage.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start pulse, rk_ready=1 -> round 0 equals key_in one cycle after start. Round 1 = a0fafe1788542cb123a339392a6c7605, round 2 = f2c295f27a96b9435935807a7359f67f, round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6. done pulses 1 cycle after round 10; rk_valid has 11 consecutive high cycles.
- Same key, with rk_ready low for 3 cycles at round 4 -> rk_out and rk_round=4 stay stable across the stall. Rounds 5..10 are unchanged from the golden values, and no round is skipped or repeated.
- start asserted at round 6 with a different key_in -> ignored. The schedule completes with the original key's golden values.
- rst high for 1 cycle at round 3 -> next cycle rk_valid=0, busy=0, rk_out=0. A fresh start with key 000102030405060708090a0b0c0d0e0f gives round 10 = 13111d7fe3944a17f307a78b4d2b30c5.
- Back-to-back: start asserted on the done cycle -> round 0 of the new key appears the following cycle.
